// File: rtl/adder_rr_sched.sv
// -----------------------------------------------------------------------------
// adder_rr_sched
//   Round-robin scheduler that shares one external combinational N-bit adder
//   among R requesters. A granted operand pair is registered onto add_a/add_b,
//   the adder gets one full cycle (EXEC) to settle, and the sum is registered
//   and returned together with the owning requester's index on a single
//   valid/ready response channel.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   req_valid  in   R      requester i has an operand pair pending
//   req_ready  out  R      one-hot grant, combinational, only non-zero in IDLE
//   req_a      in   R*N    operand A, requester i at [i*N +: N]
//   req_b      in   R*N    operand B, requester i at [i*N +: N]
//   add_a      out  N      registered operand A to the shared adder
//   add_b      out  N      registered operand B to the shared adder
//   add_sum    in   N      sum returned by the shared adder
//   rsp_valid  out  1      response available
//   rsp_ready  in   1      consumer accepts the response
//   rsp_id     out  IDW    requester index that owns rsp_sum
//   rsp_sum    out  N      registered (A+B) mod 2^N
//   busy       out  1      high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module adder_rr_sched #(
  parameter  int N   = 32,
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  input  logic [N-1:0]     add_sum,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [N-1:0]     rsp_sum,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [IDW-1:0]   ptr_q,       ptr_d;
  logic [N-1:0]     add_a_q,     add_a_d;
  logic [N-1:0]     add_b_q,     add_b_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic [N-1:0]     rsp_sum_q,   rsp_sum_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             grant_found_s;
  logic [IDW-1:0]   grant_idx_s;
  logic [R-1:0]     grant_oh_s;
  logic [N-1:0]     sel_a_s;
  logic [N-1:0]     sel_b_s;

  // Rotating-priority search: first valid requester at ptr, ptr+1, ... mod R.
  always_comb begin
    int             idx_v;
    logic [IDW-1:0] idx_s;
    grant_found_s = 1'b0;
    grant_idx_s   = {IDW{1'b0}};
    idx_v         = 0;
    idx_s         = {IDW{1'b0}};
    for (int k = 0; k < R; k++) begin
      idx_v = int'(ptr_q) + k;
      if (idx_v >= R) begin
        idx_v = idx_v - R;
      end else begin
        idx_v = idx_v;
      end
      idx_s = IDW'(idx_v);
      if (!grant_found_s && req_valid[idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot grant vector and operand mux for the selected requester.
  always_comb begin
    grant_oh_s = {R{1'b0}};
    sel_a_s    = {N{1'b0}};
    sel_b_s    = {N{1'b0}};
    for (int i = 0; i < R; i++) begin
      if (grant_found_s && (grant_idx_s == IDW'(i))) begin
        grant_oh_s[i] = 1'b1;
        sel_a_s       = req_a[i*N +: N];
        sel_b_s       = req_b[i*N +: N];
      end else begin
        grant_oh_s[i] = 1'b0;
      end
    end
  end

  // Grant is only offered in IDLE and is suppressed while reset is asserted,
  // so a handshake can never be observed during reset.
  always_comb begin
    if ((state_q == ST_IDLE) && !rst) begin
      req_ready = grant_oh_s;
    end else begin
      req_ready = {R{1'b0}};
    end
  end

  // Next-state and datapath register inputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        // In IDLE any found grant is also a completed handshake.
        if (grant_found_s) begin
          add_a_d  = sel_a_s;
          add_b_d  = sel_b_s;
          rsp_id_d = grant_idx_s;
          if (grant_idx_s == IDW'(R - 1)) begin
            ptr_d = {IDW{1'b0}};
          end else begin
            ptr_d = grant_idx_s + {{(IDW-1){1'b0}}, 1'b1};
          end
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // add_a/add_b have been stable for a whole cycle; capture the sum.
        rsp_sum_d   = add_sum;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {IDW{1'b0}};
      add_a_q     <= {N{1'b0}};
      add_b_q     <= {N{1'b0}};
      rsp_id_q    <= {IDW{1'b0}};
      rsp_sum_q   <= {N{1'b0}};
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_adder_rr_sched
//   Directed checks of adder_rr_sched (reset, single request, wrap-around,
//   fairness, backpressure, reset mid-transaction) followed by a randomized
//   run scored against a small behavioural model of the scheduler.
// -----------------------------------------------------------------------------
module tb_adder_rr_sched;

  localparam int N   = 32;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic             clk;
  logic             rst;
  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_ready;
  logic [R*N-1:0]   req_a;
  logic [R*N-1:0]   req_b;
  logic [N-1:0]     add_a;
  logic [N-1:0]     add_b;
  logic [N-1:0]     add_sum;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [N-1:0]     rsp_sum;
  logic             busy;

  logic [N-1:0]     op_a [R];
  logic [N-1:0]     op_b [R];

  int n_total = 0;
  int n_bad   = 0;

  // random-phase model state
  int               m_state;
  int               m_ptr;
  int               m_id;
  logic [N-1:0]     m_sum;
  logic [R-1:0]     pend;
  logic [R-1:0]     exp_rdy;
  int               g;
  int               idx;
  int               done;
  int               cyc;

  logic [N-1:0]     fair_sum [4];

  adder_rr_sched #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  // Stand-in for the shared combinational adder.
  assign add_sum = add_a + add_b;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < R; i++) begin
      req_a[i*N +: N] = op_a[i];
      req_b[i*N +: N] = op_b[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction from an IDLE start, rsp_ready low on entry.
  task automatic run_one(input string tag, input logic [R-1:0] vmask, input int gid,
                         input logic [N-1:0] ea, input logic [N-1:0] eb,
                         input logic [N-1:0] esum);
    logic [R-1:0] oh;
    oh = 4'b0001 << gid;
    req_valid = vmask;
    #1;
    check_eq({tag, "_rdy"}, 64'(req_ready), 64'(oh));
    @(posedge clk); #1;
    req_valid[gid] = 1'b0;
    check_eq({tag, "_exec_busy"}, 64'(busy), 64'(1));
    check_eq({tag, "_exec_rdy"}, 64'(req_ready), 64'(0));
    check_eq({tag, "_exec_rv"}, 64'(rsp_valid), 64'(0));
    check_eq({tag, "_add_a"}, 64'(add_a), 64'(ea));
    check_eq({tag, "_add_b"}, 64'(add_b), 64'(eb));
    @(posedge clk); #1;
    check_eq({tag, "_rv"}, 64'(rsp_valid), 64'(1));
    check_eq({tag, "_id"}, 64'(rsp_id), 64'(gid));
    check_eq({tag, "_sum"}, 64'(rsp_sum), 64'(esum));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_done_rv"}, 64'(rsp_valid), 64'(0));
    check_eq({tag, "_done_busy"}, 64'(busy), 64'(0));
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < R; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    check_eq("rst_rdy", 64'(req_ready), 64'(0));
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_rv", 64'(rsp_valid), 64'(0));
    check_eq("rst_id", 64'(rsp_id), 64'(0));
    check_eq("rst_sum", 64'(rsp_sum), 64'(0));
    check_eq("rst_add_a", 64'(add_a), 64'(0));
    check_eq("rst_add_b", 64'(add_b), 64'(0));

    // ---- single request ----
    @(posedge clk); #1;
    op_a[0] = 32'd1;
    op_b[0] = 32'd1;
    run_one("t1", 4'b0001, 0, 32'd1, 32'd1, 32'd2);

    // ---- wrap-around ----
    op_a[2] = 32'hFFFF_FFFF;
    op_b[2] = 32'h0000_0001;
    run_one("t2w", 4'b0100, 2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    op_a[2] = 32'h1234_5678;
    op_b[2] = 32'h8765_4321;
    run_one("t2b", 4'b0100, 2, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999);

    // ---- fairness (pointer back to 0 via reset) ----
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op_a[0] = 32'h10; op_b[0] = 32'h1;
    op_a[1] = 32'h20; op_b[1] = 32'h2;
    op_a[2] = 32'h30; op_b[2] = 32'h3;
    op_a[3] = 32'h40; op_b[3] = 32'h4;
    fair_sum[0] = 32'h11;
    fair_sum[1] = 32'h22;
    fair_sum[2] = 32'h33;
    fair_sum[3] = 32'h44;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [R-1:0] oh;
      oh = 4'b0001 << (k % 4);
      #1;
      check_eq($sformatf("t3_rdy%0d", k), 64'(req_ready), 64'(oh));
      @(posedge clk); #1;
      check_eq($sformatf("t3_exec_rdy%0d", k), 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      check_eq($sformatf("t3_rv%0d", k), 64'(rsp_valid), 64'(1));
      check_eq($sformatf("t3_id%0d", k), 64'(rsp_id), 64'(k % 4));
      check_eq($sformatf("t3_sum%0d", k), 64'(rsp_sum), 64'(fair_sum[k % 4]));
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    rsp_ready = 1'b0;
    // pointer now sits at 2

    // ---- backpressure ----
    op_a[1] = 32'd5;
    op_b[1] = 32'd7;
    req_valid = 4'b0010;
    #1;
    check_eq("t4_rdy", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      check_eq($sformatf("t4_rv%0d", c), 64'(rsp_valid), 64'(1));
      check_eq($sformatf("t4_id%0d", c), 64'(rsp_id), 64'(1));
      check_eq($sformatf("t4_sum%0d", c), 64'(rsp_sum), 64'(12));
      check_eq($sformatf("t4_rdy%0d", c), 64'(req_ready), 64'(0));
      if (c < 5) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t4_rel_rv", 64'(rsp_valid), 64'(0));
    check_eq("t4_resume_rdy", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;
    rsp_ready = 1'b0;

    // ---- reset mid-EXEC ----
    op_a[3] = 32'd3;
    op_b[3] = 32'd4;
    req_valid = 4'b1000;
    #1;
    check_eq("t5e_rdy", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1;
    req_valid = '0;
    check_eq("t5e_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check_eq("t5e_rst_busy", 64'(busy), 64'(0));
    check_eq("t5e_rst_add_a", 64'(add_a), 64'(0));
    check_eq("t5e_rst_rv", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_eq($sformatf("t5e_norsp%0d", c), 64'(rsp_valid), 64'(0));
    end

    // ---- reset mid-RESP ----
    op_a[0] = 32'd10;
    op_b[0] = 32'd20;
    req_valid = 4'b0001;
    #1;
    check_eq("t5r_rdy", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    check_eq("t5r_rv", 64'(rsp_valid), 64'(1));
    check_eq("t5r_sum", 64'(rsp_sum), 64'(30));
    rst = 1'b1;
    #1;
    check_eq("t5r_rst_rv", 64'(rsp_valid), 64'(0));
    check_eq("t5r_rst_sum", 64'(rsp_sum), 64'(0));
    check_eq("t5r_rst_id", 64'(rsp_id), 64'(0));
    check_eq("t5r_rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    // pointer must be back at 0: with 3 and 0 valid, 0 wins
    req_valid = 4'b1001;
    #1;
    check_eq("t5r_ptr0_rdy", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;

    // ---- random ----
    @(posedge clk); #1;
    pend    = '0;
    m_state = 0;
    m_ptr   = 0;
    m_id    = 0;
    m_sum   = '0;
    done    = 0;
    cyc     = 0;
    while (done < 200 && cyc < 20000) begin
      for (int i = 0; i < R; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          op_a[i] = $urandom;
          op_b[i] = $urandom;
        end
      end
      req_valid = pend;
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = '0;
      g = -1;
      if (m_state == 0) begin
        for (int k = 0; k < R; k++) begin
          idx = (m_ptr + k) % R;
          if (g < 0 && pend[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_eq("rnd_rdy", 64'(req_ready), 64'(exp_rdy));
      check_eq("rnd_busy", 64'(busy), 64'(m_state != 0));
      check_eq("rnd_rv", 64'(rsp_valid), 64'(m_state == 2));
      if (m_state == 2) begin
        check_eq("rnd_id", 64'(rsp_id), 64'(m_id));
        check_eq("rnd_sum", 64'(rsp_sum), 64'(m_sum));
      end
      case (m_state)
        0: if (g >= 0) begin
             m_id    = g;
             m_sum   = op_a[g] + op_b[g];
             pend[g] = 1'b0;
             m_ptr   = (g + 1) % R;
             m_state = 1;
           end
        1: m_state = 2;
        2: if (rsp_ready) begin
             m_state = 0;
             done++;
           end
        default: m_state = 0;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("rnd_done", 64'(done), 64'(200));
    req_valid = '0;
    rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
